// File: rtl/tone_detector.sv
// tone_detector: measures the full period of an incoming square-wave tone in
// clk cycles. It flags periods that fall within TOL of the divider's expected
// period, asserts lock after LOCK_N consecutive matches, and pulses timeout
// when no rising edge arrives for TIMEOUT cycles.
module tone_detector #(
  parameter int CNT_W    = 18,
  parameter int HALF_CNT = 63_776,
  parameter int TOL      = 256,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 200_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             match,
  output logic             locked,
  output logic             timeout
);

  localparam int EXP  = 2 * (HALF_CNT + 1);
  localparam int LO   = (EXP > TOL) ? (EXP - TOL) : 0;
  localparam int HI   = EXP + TOL;
  localparam int MC_W = $clog2(LOCK_N + 1);

  localparam logic [31:0]      LO_U     = 32'(LO);
  localparam logic [31:0]      HI_U     = 32'(HI);
  localparam logic [CNT_W-1:0] TERM     = CNT_W'(TIMEOUT - 1);
  localparam logic [MC_W-1:0]  LOCK_CNT = MC_W'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [MC_W-1:0]  match_cnt;
  logic             tone_s1;
  logic             tone_s2;
  logic             tone_s3;
  logic             rise;
  logic [CNT_W:0]   p_next;
  logic             hit;
  logic [MC_W-1:0]  mc_inc;

  // Window test is done at 32 bits so neither bound can wrap.
  function automatic logic in_window(input logic [CNT_W:0] p);
    logic [31:0] pw;
    pw = 32'(p);
    return (pw >= LO_U) && (pw <= HI_U);
  endfunction

  // Consecutive-match counter saturates at LOCK_N.
  function automatic logic [MC_W-1:0] sat_inc(input logic [MC_W-1:0] c);
    return (c >= LOCK_CNT) ? LOCK_CNT : c + 1'b1;
  endfunction

  // Synchronize the asynchronous tone and keep one extra flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_s1 <= 1'b0;
      tone_s2 <= 1'b0;
      tone_s3 <= 1'b0;
    end else begin
      tone_s1 <= tone_in;
      tone_s2 <= tone_s1;
      tone_s3 <= tone_s2;
    end
  end

  assign rise = tone_s2 & ~tone_s3;

  // Candidate period and its classification, used only when a rise lands in MEASURE.
  always_comb begin
    p_next = {1'b0, cnt} + 1'b1;
    hit    = in_window(p_next);
    mc_inc = sat_inc(match_cnt);
  end

  // Measurement FSM: arm on the first rise, report each later rise-to-rise gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      match        <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (!en) begin
        // Disabling discards any partial count and clears lock; last result holds.
        state     <= IDLE;
        cnt       <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
          end
          ARM: begin
            if (rise) begin
              cnt   <= '0;
              state <= MEASURE;
            end else if (cnt == TERM) begin
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          MEASURE: begin
            // A rise on the terminal count wins over the timeout.
            if (rise) begin
              period       <= p_next[CNT_W-1:0];
              period_valid <= 1'b1;
              match        <= hit;
              if (hit) begin
                match_cnt <= mc_inc;
                locked    <= (mc_inc == LOCK_CNT);
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end
              cnt <= '0;
            end else if (cnt == TERM) begin
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              cnt       <= '0;
              state     <= ARM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Testbench for tone_detector: directed and random tone patterns checked every
// cycle against a timestamp-based reference model.
module tb_tone_detector;

  localparam int CNT_W    = 8;
  localparam int HALF_CNT = 9;
  localparam int TOL      = 1;
  localparam int LOCK_N   = 3;
  localparam int TIMEOUT  = 50;
  localparam int EXP      = 2 * (HALF_CNT + 1);

  logic             clk;
  logic             rst;
  logic             en;
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             match;
  logic             locked;
  logic             timeout;

  tone_detector #(
    .CNT_W   (CNT_W),
    .HALF_CNT(HALF_CNT),
    .TOL     (TOL),
    .LOCK_N  (LOCK_N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .tone_in     (tone_in),
    .period      (period),
    .period_valid(period_valid),
    .match       (match),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int seen_pv  = 0;
  int seen_lk  = 0;
  int seen_to  = 0;
  int seen_mm  = 0;

  // Reference model: time of each edge, mode, and time of last reference point.
  int   m_t     = 0;
  int   m_mode  = 0;  // 0 disabled/idle, 1 waiting for first rise, 2 measuring
  int   m_base  = 0;
  int   m_cons  = 0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic [CNT_W-1:0] e_period = '0;
  logic e_pv = 1'b0, e_match = 1'b0, e_locked = 1'b0, e_to = 1'b0;

  task automatic model_step();
    logic r;
    int   p;
    r = h2 & ~h3;
    m_t++;
    e_pv = 1'b0;
    e_to = 1'b0;
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      m_mode = 0; m_cons = 0;
      e_period = '0; e_match = 1'b0; e_locked = 1'b0;
    end else begin
      h3 = h2; h2 = h1; h1 = tone_in;
      if (!en) begin
        m_mode = 0; m_cons = 0; e_locked = 1'b0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_base = m_t;
      end else if (r) begin
        if (m_mode == 2) begin
          p = m_t - m_base;
          e_period = CNT_W'(p);
          e_pv = 1'b1;
          e_match = (p >= EXP - TOL) && (p <= EXP + TOL);
          m_cons = e_match ? m_cons + 1 : 0;
          e_locked = (m_cons >= LOCK_N);
        end
        m_mode = 2; m_base = m_t;
      end else if (m_t - m_base == TIMEOUT) begin
        e_to = 1'b1; e_locked = 1'b0; m_cons = 0;
        m_mode = 1; m_base = m_t;
      end
    end
  endtask

  task automatic check_all();
    n_checks += 5;
    assert (period === e_period) else begin
      n_err++; $error("FAIL period t=%0d observed %0d expected %0d", m_t, period, e_period);
    end
    assert (period_valid === e_pv) else begin
      n_err++; $error("FAIL period_valid t=%0d observed %0b expected %0b", m_t, period_valid, e_pv);
    end
    assert (match === e_match) else begin
      n_err++; $error("FAIL match t=%0d observed %0b expected %0b", m_t, match, e_match);
    end
    assert (locked === e_locked) else begin
      n_err++; $error("FAIL locked t=%0d observed %0b expected %0b", m_t, locked, e_locked);
    end
    assert (timeout === e_to) else begin
      n_err++; $error("FAIL timeout t=%0d observed %0b expected %0b", m_t, timeout, e_to);
    end
    if (period_valid === 1'b1) seen_pv++;
    if (period_valid === 1'b1 && match === 1'b0) seen_mm++;
    if (locked === 1'b1) seen_lk++;
    if (timeout === 1'b1) seen_to++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic tone_period(input int hi, input int lo);
    tone_in = 1'b1;
    repeat (hi) tick();
    tone_in = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tone_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Nominal tone, lock after three matching periods.
    en = 1'b1;
    repeat (6) tone_period(10, 10);
    // Off-frequency tone breaks lock, then relock.
    repeat (2) tone_period(12, 12);
    repeat (5) tone_period(10, 10);
    // Tolerance edges.
    tone_period(10, 9);
    tone_period(10, 11);
    tone_period(9, 9);
    tone_period(11, 11);
    repeat (4) tone_period(10, 10);
    // Stuck low: repeated timeouts, then restart.
    repeat (160) tick();
    repeat (5) tone_period(10, 10);
    // Enable gap mid-period.
    tone_in = 1'b1;
    repeat (4) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    repeat (6) tick();
    tone_in = 1'b0;
    repeat (10) tick();
    repeat (5) tone_period(10, 10);
    // Reset mid-measurement.
    tone_in = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tone_in = 1'b0;
    repeat (3) tick();
    repeat (6) tone_period(10, 10);
    // Period exactly at the timeout count: rise wins.
    tone_period(25, 25);
    tone_period(25, 26);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      int act;
      act = int'($urandom_range(0, 11));
      if (act == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 6)) tick();
        en = 1'b1;
      end else if (act == 1) begin
        repeat ($urandom_range(40, 120)) tick();
      end else if (act == 2) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tone_period(int'($urandom_range(8, 13)), int'($urandom_range(8, 13)));
      end
    end

    // The run must have exercised each kind of output event.
    n_checks += 4;
    assert (seen_pv > 0) else begin
      n_err++; $error("FAIL seen_period_valid observed %0d expected >0", seen_pv);
    end
    assert (seen_lk > 0) else begin
      n_err++; $error("FAIL seen_locked observed %0d expected >0", seen_lk);
    end
    assert (seen_to > 0) else begin
      n_err++; $error("FAIL seen_timeout observed %0d expected >0", seen_to);
    end
    assert (seen_mm > 0) else begin
      n_err++; $error("FAIL seen_mismatch observed %0d expected >0", seen_mm);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
Receive-side counterpart to the 784 Hz tone divider. It measures the full period of an incoming square-wave tone in system-clock cycles and reports each measured period. It flags whether the period matches the divider's expected tone, and asserts lock after consecutive matches. It is used for self-check and loopback of the song player's tone output, and for detecting an externally applied tone.

Parameters:
CNT_W, 18, width of the period counter and the period output
HALF_CNT, 63_776, divider half-period compare value; expected period EXP = 2*(HALF_CNT+1) = 127_554 cycles
TOL, 256, allowed |period - EXP| in cycles for a match (inclusive)
LOCK_N, 4, consecutive matching periods required to assert locked
TIMEOUT, 200_000, cycles without a rising edge before the tone is declared absent; must be <= 2^CNT_W - 1

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
en  in  1  detector enable
tone_in  in  1  asynchronous square-wave tone input
period  out  CNT_W  last measured full period in clk cycles
period_valid  out  1  one-cycle pulse when period updates
match  out  1  last measured period within EXP±TOL; valid alongside period, held until the next update
locked  out  1  LOCK_N consecutive matching periods observed
timeout  out  1  one-cycle pulse when no edge is seen for TIMEOUT cycles

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: period=0, period_valid=0, match=0, locked=0, timeout=0, state=IDLE, counters=0, synchronizer flops=0.
- Input path: 2-flop synchronizer s1→s2, plus s3 for edge detection. A rise is detected on a cycle where s2=1 and s3=0. The synchronizer runs regardless of en.
- States:
  - IDLE: entered on reset or whenever en=0, from any state, in the same cycle. cnt=0, match_cnt=0, locked=0. period and match hold their values. Goes to ARM when en=1.
  - ARM: waits for the first rise and emits no period. On a rise: cnt<=0, go to MEASURE. cnt also runs here for the timeout check.
  - MEASURE: cnt increments every cycle. On a rise:
    - period<=cnt+1; period_valid=1 on the next cycle.
    - cnt<=0; stay in MEASURE.
    - Result: edges detected N cycles apart report period=N.
- Match arithmetic: compare at CNT_W+1 bits to avoid wrap. match = (period >= EXP-TOL) && (period <= EXP+TOL). If EXP-TOL < 0, treat the lower bound as 0.
- Lock counter:
  - Updates in the same cycle period/match update, so locked changes in the cycle period_valid is high.
  - On match: match_cnt increments, saturating at LOCK_N. locked=1 once match_cnt reaches LOCK_N.
  - On mismatch: match_cnt<=0, locked<=0.
- Timeout: in ARM or MEASURE, if cnt reaches TIMEOUT-1 with no rise in that cycle:
  - timeout pulses for 1 cycle, locked<=0, match_cnt<=0, cnt<=0, go to ARM.
  - No period_valid is emitted.
  - A rise in the same cycle as the terminal count wins: the period is reported and no timeout fires.
- The counter never wraps, because timeout fires before 2^CNT_W.
- en dropping mid-measurement discards the partial count; no period_valid or timeout is emitted.
- Reset mid-operation returns all state to reset values on the next edge.
- DC input (stuck high or low) produces a repeating timeout every TIMEOUT cycles and locked=0.

Test Plan:
Use CNT_W=8, HALF_CNT=9 (EXP=20), TOL=1, LOCK_N=3, TIMEOUT=50 unless noted.
1. Reset, then en=1 with tone_in toggling every 10 clk → first rise gives no output; then period_valid pulses every 20 cycles with period=20 and match=1; locked=1 on the 3rd valid pulse.
2. Locked at 20, then switch to half-period 12 (period 24) → first period=24 gives match=0 and locked=0 in that same cycle; return to period 20 → locked after 3 more valid pulses.
3. Periods 19 and 21 → match=1; periods 18 and 22 → match=0 (tolerance boundaries).
4. Locked, then hold tone_in=0 → timeout pulses 50 cycles after the last rise, locked=0, and timeout repeats every 50 cycles; restarting the tone → first rise rearms with no period, second rise reports period=20.
5. Drop en for 5 cycles mid-period, then restore → locked=0, no period_valid during the gap, and the first rise after en is not reported; with full defaults, a divider-driven tone reports period=127_554 with match=1.
6. Assert rst mid-measurement → all outputs 0 on the next cycle, and the lock sequence restarts from scratch.
